parameter_bank: RTL
===================

// Module: parameter_bank
// PURPOSE
//  Multi-channel successor of the single-set MIDI parameter register: one synth parameter set per MIDI channel.
//  Adds preset recall (PROGRAM_CHANGE) and preset store (CC STORE_PRESET) through an on-chip preset RAM.
//  Sits between the MIDI message decoder and the voice/envelope/mixer blocks; consumes one message per handshake.
// PARAMETERS
//  NUM_CHANNELS  4  parameter sets kept; MIDI channels 0..NUM_CHANNELS-1 served, others ignored
//  NUM_PRESETS   8  preset slots in RAM; program numbers >= NUM_PRESETS ignored
//  NUM_PARAMS    7  fields per set (tempo, unison_detune, attack, decay, sustain, release, volume)
//  VALUE_W       7  width of each field (MIDI data byte)
// PORTS
//  clock_50_000_000    in   1                        system clock
//  reset               in   1                        asynchronous, active-high reset
//  message             in   $bits(MIDI::message_t)   decoded MIDI message (type, channel, data_byte1/2)
//  message_valid       in   1                        message holds a valid message
//  message_ready       out  1                        block can accept; transfer = valid & ready
//  parameters          out  NUM_CHANNELS x PARAMETER::parameter_t   live parameter set per channel
//  parameters_updated  out  NUM_CHANNELS             1-cycle pulse: that channel's set changed
//  busy                out  1                        preset LOAD/STORE in progress (= !message_ready)
// BEHAVIOUR
//  Reset (async, active-high): every parameters[c] <= PARAMETER::DEFAULT_PARAMETERS; state IDLE;
//   parameters_updated '0; message_ready 1; busy 0; counters 0. Preset RAM is not reset.
//  Preset RAM: NUM_PRESETS*NUM_PARAMS words of VALUE_W, addr = slot*NUM_PARAMS + field; single port;
//   synchronous read, 1-cycle latency. Power-up content: every slot = DEFAULT_PARAMETERS.
//  FSM states: IDLE, LOAD, STORE. message_ready = (state == IDLE).
//  IDLE, accepted message, ch = message.channel:
//   - ch >= NUM_CHANNELS: message dropped, no state change.
//   - CONTROL_CHANGE, controller maps to a field: parameters[ch].field <= value on the next edge;
//     parameters_updated[ch] pulses in the same cycle the new value appears.
//   - CONTROL_CHANGE STORE_PRESET: value < NUM_PRESETS -> latch ch, slot = value, idx = 0, go to STORE;
//     otherwise dropped.
//   - PROGRAM_CHANGE: program < NUM_PRESETS -> latch ch, slot = program, idx = 0, go to LOAD;
//     otherwise dropped.
//   - Other controllers and message types: accepted and dropped.
//  LOAD: issue RAM read of field idx each cycle for idx = 0..NUM_PARAMS-1.
//   - Read data for field k lands in parameters[ch].k one cycle later.
//   - After the last write, return to IDLE and pulse parameters_updated[ch].
//   - Total NUM_PARAMS+1 cycles busy (8 by default).
//   - Fields not yet reloaded keep their old value; intermediate mix is visible (no double buffering).
//  STORE: write parameters[ch] field idx to RAM each cycle for idx = 0..NUM_PARAMS-1, then IDLE.
//   - NUM_PARAMS cycles busy; no parameters_updated pulse.
//  idx counter is $clog2(NUM_PARAMS) wide. Terminates at NUM_PARAMS-1 and never wraps past it.
//  Back-to-back CCs in IDLE: one accepted per cycle, each applied in order; last write wins per field.
//  While busy: message_ready 0; the upstream holds the message; nothing is dropped.
//  Reset during LOAD/STORE: abort immediately.
//   - LOAD: parameters return to defaults.
//   - STORE: a partially written slot is left as-is (documented, not an error).
// STRUCTURE
//  PARAMETER package:
//   - param_index_t enum (field order = RAM order)
//   - parameter_t packed struct
//   - DEFAULT_PARAMETERS constant
//   - function get_field / set_field(parameter_t, param_index_t, value)
//  MIDI package:
//   - controller constants TEMPO..VOLUME plus STORE_PRESET (= 85)
//   - function cc_to_index returning {hit, param_index_t}
//  Sub-module: preset_ram (parametrised depth/width, single-port, sync read, initial content loop);
//   everything else inline.
// TESTING
//  1. Reset; CC ATTACK=0x40 on ch1 -> next cycle parameters[1].attack_time=0x40,
//     parameters_updated=4'b0010; ch0/2/3 stay default.
//  2. CC VOLUME=0x7F on ch5 (NUM_CHANNELS=4) -> accepted, no output change, no pulse.
//  3. ch2 set SUSTAIN=0x11, CC STORE_PRESET=3 -> busy 7 cycles; reset; PROGRAM_CHANGE 3 on ch0
//     -> busy 8 cycles, then parameters[0].sustain_level=0x11, pulse 4'b0001.
//  4. PROGRAM_CHANGE 9 (>= NUM_PRESETS) -> ready stays 1, no change; CC TEMPO held valid during LOAD
//     -> held until ready, then applied.
//  5. Assert reset mid-LOAD (cycle 3) -> all outputs at reset values the same cycle; ready=1 after release.
//  6. Random CC/PC/STORE stream vs. reference model (scoreboard on parameters and pulse timing),
//     with valid toggling and back-pressure.

Source files
------------

// File: rtl/parameter_bank_pkg.sv
// Shared types for the parameter bank: parameter fields, MIDI message layout and controller map.
package parameter_bank_pkg;

    localparam int unsigned VALUE_W    = 7;
    localparam int unsigned NUM_PARAMS = 7;
    localparam int unsigned IDX_W      = $clog2(NUM_PARAMS);

    // Field order is also the word order of a preset slot in RAM
    typedef enum logic [2:0] {
        FIELD_TEMPO         = 3'd0,
        FIELD_UNISON_DETUNE = 3'd1,
        FIELD_ATTACK        = 3'd2,
        FIELD_DECAY         = 3'd3,
        FIELD_SUSTAIN       = 3'd4,
        FIELD_RELEASE       = 3'd5,
        FIELD_VOLUME        = 3'd6
    } param_index_t;

    typedef struct packed {
        logic [VALUE_W-1:0] tempo;
        logic [VALUE_W-1:0] unison_detune;
        logic [VALUE_W-1:0] attack_time;
        logic [VALUE_W-1:0] decay_time;
        logic [VALUE_W-1:0] sustain_level;
        logic [VALUE_W-1:0] release_time;
        logic [VALUE_W-1:0] volume;
    } parameter_t;

    localparam int unsigned PARAMETER_W = $bits(parameter_t);

    localparam parameter_t DEFAULT_PARAMETERS = '{
        tempo:         7'd60,
        unison_detune: 7'd0,
        attack_time:   7'd10,
        decay_time:    7'd20,
        sustain_level: 7'd100,
        release_time:  7'd30,
        volume:        7'd100
    };

    typedef enum logic [2:0] {
        NOTE_OFF         = 3'd0,
        NOTE_ON          = 3'd1,
        POLY_PRESSURE    = 3'd2,
        CONTROL_CHANGE   = 3'd3,
        PROGRAM_CHANGE   = 3'd4,
        CHANNEL_PRESSURE = 3'd5,
        PITCH_BEND       = 3'd6,
        SYSTEM           = 3'd7
    } message_type_t;

    typedef struct packed {
        message_type_t      message_type;
        logic [3:0]         channel;
        logic [VALUE_W-1:0] data_byte1;
        logic [VALUE_W-1:0] data_byte2;
    } message_t;

    localparam int unsigned MESSAGE_W = $bits(message_t);

    localparam logic [VALUE_W-1:0] CC_VOLUME        = 7'd7;
    localparam logic [VALUE_W-1:0] CC_TEMPO         = 7'd14;
    localparam logic [VALUE_W-1:0] CC_UNISON_DETUNE = 7'd15;
    localparam logic [VALUE_W-1:0] CC_SUSTAIN       = 7'd70;
    localparam logic [VALUE_W-1:0] CC_RELEASE       = 7'd72;
    localparam logic [VALUE_W-1:0] CC_ATTACK        = 7'd73;
    localparam logic [VALUE_W-1:0] CC_DECAY         = 7'd75;
    localparam logic [VALUE_W-1:0] CC_STORE_PRESET  = 7'd85;

    typedef struct packed {
        logic         hit;
        param_index_t index;
    } cc_map_t;

    function automatic cc_map_t cc_to_index(input logic [VALUE_W-1:0] controller);
        cc_map_t map;
        map.hit   = 1'b1;
        map.index = FIELD_TEMPO;
        case (controller)
            CC_TEMPO:         map.index = FIELD_TEMPO;
            CC_UNISON_DETUNE: map.index = FIELD_UNISON_DETUNE;
            CC_ATTACK:        map.index = FIELD_ATTACK;
            CC_DECAY:         map.index = FIELD_DECAY;
            CC_SUSTAIN:       map.index = FIELD_SUSTAIN;
            CC_RELEASE:       map.index = FIELD_RELEASE;
            CC_VOLUME:        map.index = FIELD_VOLUME;
            default:          map.hit   = 1'b0;
        endcase
        return map;
    endfunction

    function automatic logic [VALUE_W-1:0] get_field(input parameter_t p, input param_index_t i);
        logic [VALUE_W-1:0] v;
        case (i)
            FIELD_TEMPO:         v = p.tempo;
            FIELD_UNISON_DETUNE: v = p.unison_detune;
            FIELD_ATTACK:        v = p.attack_time;
            FIELD_DECAY:         v = p.decay_time;
            FIELD_SUSTAIN:       v = p.sustain_level;
            FIELD_RELEASE:       v = p.release_time;
            FIELD_VOLUME:        v = p.volume;
            default:             v = '0;
        endcase
        return v;
    endfunction

    function automatic parameter_t set_field(input parameter_t p, input param_index_t i,
                                             input logic [VALUE_W-1:0] v);
        parameter_t r;
        r = p;
        case (i)
            FIELD_TEMPO:         r.tempo         = v;
            FIELD_UNISON_DETUNE: r.unison_detune = v;
            FIELD_ATTACK:        r.attack_time   = v;
            FIELD_DECAY:         r.decay_time    = v;
            FIELD_SUSTAIN:       r.sustain_level = v;
            FIELD_RELEASE:       r.release_time  = v;
            FIELD_VOLUME:        r.volume        = v;
            default:             r = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/parameter_bank_preset_ram.sv
// Single-port preset RAM, synchronous read; every slot powers up holding INIT_SLOT (word 0 in the MSBs).
module parameter_bank_preset_ram #(
    parameter int unsigned DEPTH          = 56,
    parameter int unsigned WIDTH          = 7,
    parameter int unsigned WORDS_PER_SLOT = 7,
    parameter int unsigned ADDR_W         = 6,
    parameter logic [WORDS_PER_SLOT*WIDTH-1:0] INIT_SLOT = '0
) (
    input  logic              clock,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  write_data,
    output logic [WIDTH-1:0]  read_data
);
    typedef logic [WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int unsigned d = 0; d < DEPTH; d++) begin
            m[d] = INIT_SLOT[(WORDS_PER_SLOT - 1 - (d % WORDS_PER_SLOT)) * WIDTH +: WIDTH];
        end
        return m;
    endfunction

    mem_t mem = init_mem();

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[address] <= write_data;
        end
        if (read_enable) begin
            read_data <= mem[address];
        end
    end

endmodule

// File: rtl/parameter_bank.sv
// Per-channel synth parameter sets driven by MIDI CCs, with preset recall (program change) and store.
module parameter_bank
    import parameter_bank_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned NUM_PRESETS  = 8
) (
    input  logic                                     clock_50_000_000,
    input  logic                                     reset,
    input  logic [MESSAGE_W-1:0]                     message,
    input  logic                                     message_valid,
    output logic                                     message_ready,
    output logic [NUM_CHANNELS-1:0][PARAMETER_W-1:0] parameters,
    output logic [NUM_CHANNELS-1:0]                  parameters_updated,
    output logic                                     busy
);
    localparam int unsigned CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned SLOT_W = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;
    localparam int unsigned DEPTH  = NUM_PRESETS * NUM_PARAMS;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PARAMS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    state_t                             state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d, rd_idx_q;
    logic [SLOT_W-1:0]                  slot_q, slot_d;
    logic [CH_W-1:0]                    ch_q, ch_d, msg_ch;
    logic                               rd_valid_q;
    parameter_t [NUM_CHANNELS-1:0]      params_q;
    message_t                           msg;
    cc_map_t                            cc;
    logic                               ch_ok, store_ok, program_ok, load_tail;
    logic                               cc_wr, load_done, ram_we, ram_re;
    logic [ADDR_W-1:0]                  ram_addr;
    logic [VALUE_W-1:0]                 ram_wdata, ram_rdata;

    assign msg        = message_t'(message);
    assign cc         = cc_to_index(msg.data_byte1);
    assign msg_ch     = CH_W'(msg.channel);
    assign ch_ok      = 32'(msg.channel) < NUM_CHANNELS;
    assign store_ok   = (msg.data_byte1 == CC_STORE_PRESET) && (32'(msg.data_byte2) < NUM_PRESETS);
    assign program_ok = 32'(msg.data_byte1) < NUM_PRESETS;
    // Last read's data is being written back this cycle
    assign load_tail  = rd_valid_q && (rd_idx_q == LAST_IDX);
    assign ram_addr   = ADDR_W'(32'(slot_q) * NUM_PARAMS + 32'(idx_q));
    assign ram_wdata  = get_field(params_q[ch_q], param_index_t'(idx_q));
    assign parameters = params_q;

    // Next-state and control decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        slot_d    = slot_q;
        ch_d      = ch_q;
        cc_wr     = 1'b0;
        load_done = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state_q)
            IDLE: begin
                if (message_valid && ch_ok) begin
                    if (msg.message_type == CONTROL_CHANGE) begin
                        if (cc.hit) begin
                            cc_wr = 1'b1;
                        end else if (store_ok) begin
                            state_d = STORE;
                            ch_d    = msg_ch;
                            slot_d  = SLOT_W'(msg.data_byte2);
                            idx_d   = '0;
                        end
                    end else if (msg.message_type == PROGRAM_CHANGE && program_ok) begin
                        state_d = LOAD;
                        ch_d    = msg_ch;
                        slot_d  = SLOT_W'(msg.data_byte1);
                        idx_d   = '0;
                    end
                end
            end
            LOAD: begin
                if (load_tail) begin
                    state_d   = IDLE;
                    load_done = 1'b1;
                end else begin
                    ram_re = 1'b1;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STORE: begin
                ram_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            idx_q              <= '0;
            slot_q             <= '0;
            ch_q               <= '0;
            rd_valid_q         <= 1'b0;
            rd_idx_q           <= '0;
            params_q           <= {NUM_CHANNELS{DEFAULT_PARAMETERS}};
            parameters_updated <= '0;
            message_ready      <= 1'b1;
            busy               <= 1'b0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            slot_q             <= slot_d;
            ch_q               <= ch_d;
            rd_valid_q         <= ram_re;
            rd_idx_q           <= idx_q;
            message_ready      <= (state_d == IDLE);
            busy               <= (state_d != IDLE);
            parameters_updated <= '0;
            if (cc_wr) begin
                params_q[msg_ch]           <= set_field(params_q[msg_ch], cc.index, msg.data_byte2);
                parameters_updated[msg_ch] <= 1'b1;
            end
            if (rd_valid_q) begin
                params_q[ch_q] <= set_field(params_q[ch_q], param_index_t'(rd_idx_q), ram_rdata);
            end
            if (load_done) begin
                parameters_updated[ch_q] <= 1'b1;
            end
        end
    end

    parameter_bank_preset_ram #(
        .DEPTH          (DEPTH),
        .WIDTH          (VALUE_W),
        .WORDS_PER_SLOT (NUM_PARAMS),
        .ADDR_W         (ADDR_W),
        .INIT_SLOT      (DEFAULT_PARAMETERS)
    ) u_preset_ram (
        .clock        (clock_50_000_000),
        .write_enable (ram_we),
        .read_enable  (ram_re),
        .address      (ram_addr),
        .write_data   (ram_wdata),
        .read_data    (ram_rdata)
    );

endmodule
